// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and FIFO write-port bundle for fifo_wr_arbiter
interface fifo_wr_arbiter_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_i;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            ready_o;
    logic [NUM_REQ-1:0]            grant_o;
    logic                          fifo_wr_en_o;
    logic [FIFO_WIDTH-1:0]         fifo_data_o;
    logic                          fifo_full_i;
    logic                          fifo_wr_ack_i;
    logic                          fifo_overflow_i;

    modport master (
        input  req_i, req_data_i, fifo_full_i, fifo_wr_ack_i, fifo_overflow_i,
        output ready_o, grant_o, fifo_wr_en_o, fifo_data_o
    );

    modport slave (
        output req_i, req_data_i, fifo_full_i, fifo_wr_ack_i, fifo_overflow_i,
        input  ready_o, grant_o, fifo_wr_en_o, fifo_data_o
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for a shared FIFO write port
// Optional per-requester beat and error counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    fifo_wr_arbiter_if.master       bus,
    output logic                    err_o
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]   beat_cnt_o,
    output logic [7:0]              err_cnt_o
`endif
);
    localparam int         IDXW      = $clog2(NUM_REQ);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_BURST  = 1'b1;
    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    logic [0:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDXW-1:0]    owner_q, owner_d;
    logic [IDXW-1:0]    last_owner_q, last_owner_d;
    logic [3:0]         beat_cnt_q, beat_cnt_d;
    logic               err_q, err_d;
    logic               pending_ack_q, pending_ack_d;

    logic                  active;
    logic                  owner_req;
    logic                  xfer;
    logic                  release_burst;
    logic                  err_set;
    logic [NUM_REQ-1:0]    others;
    logic [FIFO_WIDTH-1:0] sel_data;

    // First requester after 'last' in circular order; 'last' itself is checked last.
    function automatic logic [IDXW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [IDXW-1:0]    last);
        int   idx;
        logic found;
        rr_pick = '0;
        found   = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (!found && r[IDXW'(idx)]) begin
                rr_pick = IDXW'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == IDXW'(k)) sel_data = bus.req_data_i[k*FIFO_WIDTH +: FIFO_WIDTH];
        end
    end

    // Outputs are gated by rst so an abandoned burst cannot write during the reset cycle.
    assign active    = !rst && (state_q == ST_BURST);
    assign owner_req = bus.req_i[owner_q];
    assign xfer      = active && owner_req && !bus.fifo_full_i;

    assign bus.ready_o      = (active && !bus.fifo_full_i) ? grant_q : '0;
    assign bus.grant_o      = grant_q;
    assign bus.fifo_wr_en_o = xfer;
    assign bus.fifo_data_o  = xfer ? sel_data : '0;
    assign err_o            = err_q;

    assign others        = bus.req_i & ~grant_q;
    assign release_burst = (xfer && (beat_cnt_q == LAST_BEAT)) || !owner_req;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req_i) begin
                    owner_d    = rr_pick(bus.req_i, last_owner_q);
                    beat_cnt_d = '0;
                    state_d    = ST_BURST;
                end
            end
            ST_BURST: begin
                if (xfer) beat_cnt_d = beat_cnt_q + 4'd1;
                if (release_burst) begin
                    last_owner_d = owner_q;
                    beat_cnt_d   = '0;
                    if (|others) begin
                        owner_d = rr_pick(others, owner_q);
                    end else if (!owner_req) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        grant_d = (state_d == ST_BURST) ? (NUM_REQ'(1) << owner_d) : '0;
    end

    assign err_set       = (bus.fifo_wr_ack_i != pending_ack_q) || bus.fifo_overflow_i;
    assign err_d         = err_q || err_set;
    assign pending_ack_d = xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            owner_q       <= '0;
            last_owner_q  <= IDXW'(NUM_REQ - 1);
            beat_cnt_q    <= '0;
            err_q         <= 1'b0;
            pending_ack_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            beat_cnt_q    <= beat_cnt_d;
            err_q         <= err_d;
            pending_ack_q <= pending_ack_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] bcnt_q [NUM_REQ];
    logic [15:0] bcnt_d [NUM_REQ];
    logic [7:0]  err_cnt_q, err_cnt_d;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            bcnt_d[k] = bcnt_q[k];
            if (xfer && (owner_q == IDXW'(k)) && (bcnt_q[k] != 16'hFFFF))
                bcnt_d[k] = bcnt_q[k] + 16'd1;
        end
        err_cnt_d = err_cnt_q;
        if (err_set && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REQ; k++) bcnt_q[k] <= '0;
            err_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) bcnt_q[k] <= bcnt_d[k];
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) beat_cnt_o[k*16 +: 16] = bcnt_q[k];
    end
    assign err_cnt_o = err_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter against a transaction-level model
module tb_fifo_wr_arbiter;
    localparam int W  = 16;
    localparam int N  = 4;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst;
    logic err_o;
`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] beat_cnt_o;
    logic [7:0]      err_cnt_o;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.FIFO_WIDTH(W), .NUM_REQ(N)) bus ();

    fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .err_o      (err_o)
`ifdef FIFO_ARB_STATS_EN
        ,
        .beat_cnt_o (beat_cnt_o),
        .err_cnt_o  (err_cnt_o)
`endif
    );

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q [$];

    // Model state: owner index (-1 = idle), beats accepted this grant, last released owner.
    int m_owner, m_beats, m_last, m_errsets;
    bit m_err, m_pend;
    int m_bcnt [N];
    int wr_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (last + i) % N;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_beats = 0; m_last = N - 1;
        m_err = 1'b0; m_pend = 1'b0; m_errsets = 0;
        for (int k = 0; k < N; k++) m_bcnt[k] = 0;
    endtask

    task automatic cycle(input logic r, input logic [N-1:0] req, input logic [N*W-1:0] data,
                         input logic full, input bit inj, input bit ov);
        logic [N-1:0] g, others;
        logic         ack;
        bit           exp_wr;
        int           k;
        @(negedge clk);
        ack                 = m_pend ^ inj;
        rst                 = r;
        bus.req_i           = req;
        bus.req_data_i      = data;
        bus.fifo_full_i     = full;
        bus.fifo_wr_ack_i   = ack;
        bus.fifo_overflow_i = ov;
        #1;
        exp_wr = !r && (m_owner >= 0) && req[m_owner] && !full;
        g      = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        chk("grant", 64'(bus.grant_o), 64'(g));
        chk("ready", 64'(bus.ready_o), 64'((!r && !full) ? g : '0));
        chk("wr_en", 64'(bus.fifo_wr_en_o), 64'(exp_wr));
        chk("err", 64'(err_o), 64'(m_err));
        if (!exp_wr) chk("data_idle", 64'(bus.fifo_data_o), 64'd0);
`ifdef FIFO_ARB_STATS_EN
        chk("err_cnt", 64'(err_cnt_o), 64'(m_errsets));
        for (int j = 0; j < N; j++) chk("beat_cnt", 64'(beat_cnt_o[j*16 +: 16]), 64'(m_bcnt[j]));
`endif
        if (bus.fifo_wr_en_o === 1'b1) wr_seen++;
        if (exp_wr) exp_q.push_back(data[m_owner*W +: W]);

        if (r) begin
            model_reset();
        end else begin
            if ((ack != m_pend) || ov) begin
                m_err = 1'b1;
                m_errsets++;
            end
            m_pend = exp_wr;
            if (m_owner < 0) begin
                k = pick(req, m_last);
                if (k >= 0) begin
                    m_owner = k;
                    m_beats = 0;
                end
            end else begin
                if (exp_wr) begin
                    m_beats++;
                    m_bcnt[m_owner]++;
                end
                if ((exp_wr && m_beats == MB) || !req[m_owner]) begin
                    m_last = m_owner;
                    others = req & ~(N'(1) << m_owner);
                    k      = pick(others, m_owner);
                    if (k >= 0) begin
                        m_owner = k;
                        m_beats = 0;
                    end else if (req[m_owner]) begin
                        m_beats = 0;
                    end else begin
                        m_owner = -1;
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (bus.fifo_wr_en_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got data %0h expected no write", bus.fifo_data_o);
                end else begin
                    chk("fifo_data", 64'(bus.fifo_data_o), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom);
        return d;
    endfunction

    localparam logic [N*W-1:0] IDX_DATA = {16'd3, 16'd2, 16'd1, 16'd0};

    initial begin
        logic [N-1:0] rq;
        logic         fl;
        rst = 1'b1;
        bus.req_i = '0; bus.req_data_i = '0; bus.fifo_full_i = 1'b0;
        bus.fifo_wr_ack_i = 1'b0; bus.fifo_overflow_i = 1'b0;
        model_reset();
        cycle(1, '0, '0, 0, 0, 0);
        cycle(1, '0, '0, 0, 0, 0);

        // Single requester: one arbitration cycle, then back-to-back writes across re-grants.
        wr_seen = 0;
        for (int i = 0; i < 12; i++) cycle(0, 4'b0001, rand_data(), 0, 0, 0);
        chk("no_bubble_writes", 64'(wr_seen), 64'd11);

        // All requesting: four-beat bursts in order 0,1,2,3,0.
        cycle(1, '0, '0, 0, 0, 0);
        wr_seen = 0;
        for (int i = 0; i < 21; i++) cycle(0, 4'b1111, IDX_DATA, 0, 0, 0);
        chk("rr_writes", 64'(wr_seen), 64'd20);

        // Requester 2 stalled by full for three cycles mid-burst.
        cycle(1, '0, '0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 4'b0100, IDX_DATA, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 4'b0100, IDX_DATA, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 4'b0100, IDX_DATA, 0, 0, 0);

        // Requester 1 drops after two beats while requester 3 waits.
        cycle(1, '0, '0, 0, 0, 0);
        cycle(0, 4'b0010, IDX_DATA, 0, 0, 0);
        cycle(0, 4'b1010, IDX_DATA, 0, 0, 0);
        cycle(0, 4'b1010, IDX_DATA, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 4'b1000, IDX_DATA, 0, 0, 0);

        // Reset in the middle of requester 1's burst, then everyone requests.
        cycle(1, '0, '0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 4'b0010, IDX_DATA, 0, 0, 0);
        cycle(1, 4'b1111, IDX_DATA, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 4'b1111, IDX_DATA, 0, 0, 0);

        // Missing write acknowledge: sticky error until reset.
        cycle(1, '0, '0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 4'b0001, rand_data(), 0, 0, 0);
        cycle(0, 4'b0001, rand_data(), 0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 4'b0000, '0, 0, 0, 0);
        chk("err_sticky", 64'(err_o), 64'd1);

        // Overflow pulse sets the error as well.
        cycle(1, '0, '0, 0, 0, 0);
        cycle(0, '0, '0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 4'b0100, rand_data(), 0, 0, 0);
        chk("err_ovf", 64'(err_o), 64'd1);

        // Randomized traffic with sticky requests and random full.
        cycle(1, '0, '0, 0, 0, 0);
        rq = '0;
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < N; k++) if ($urandom_range(3) == 0) rq[k] = ~rq[k];
            fl = ($urandom_range(3) == 0);
            cycle(($urandom_range(79) == 0), rq, rand_data(), fl, 0, 0);
        end

        cycle(0, '0, '0, 0, 0, 0);
        #3;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
